data_memory_unit: RTL and testbench

Parametrised successor to the CPU's single-cycle word data memory. Serves byte, halfword and word loads and stores (signed and unsigned) over a valid/ready request channel. Read data and errors return after a programmable fixed latency, and misaligned or out-of-range accesses are flagged instead of silently aliasing. It sits between the CPU's ALU address output and the register file write-back path.

---
 rtl/data_memory_unit_if.sv | 33 +++
 rtl/data_memory_unit.sv | 206 ++++++++++++++++++++
 tb/tb_data_memory_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_unit_if.sv
// Request/response bus of the data memory unit.
//   req_valid / req_ready : request handshake, accept on valid & ready at a rising edge
//   req_write             : 1 = store, 0 = load
//   req_size              : 00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned          : loads only, zero-extend instead of sign-extend
//   req_addr              : byte address
//   req_wdata             : right-aligned store data
//   resp_valid            : one-cycle response strobe (loads and stores)
//   resp_rdata            : extended load data, 0 for stores and errors
//   resp_error            : misaligned, illegal size or out-of-range access
// master = requester (CPU side), slave = the memory unit.
interface data_memory_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_unit.sv
// Data memory unit: byte/halfword/word loads and stores (signed and unsigned) on a
// valid/ready request channel, with a fixed programmable response latency.
//   DEPTH   : memory size in 32-bit words (power of two, 16..65536)
//   LATENCY : cycles from request acceptance to response (1..4)
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : request/response channel (slave side)
// Misaligned, illegal-size and out-of-range accesses return resp_error=1 and never
// touch the array. Array contents are not reset.
module data_memory_unit #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  data_memory_unit_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [1:0]  CntLoad = 2'(LATENCY - 1);
  // With single-cycle latency the accepting edge is also the edge that enters RESP,
  // so the array is accessed with the live request fields instead of the captured ones.
  localparam bit          Direct  = (LATENCY == 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;

  // Request fields captured at accept
  logic        cap_write;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  // Access outcome captured on the edge that enters RESP
  logic        rd_write;
  logic        rd_error;
  logic        rd_unsigned;
  logic [1:0]  rd_size;
  logic [1:0]  rd_lane;
  logic [31:0] rd_word;

  logic        resp_valid_q;
  logic        resp_error_q;
  logic [31:0] resp_rdata_q;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        src_write;
  logic [1:0]  src_size;
  logic        src_unsigned;
  logic [31:0] src_addr;
  logic [31:0] src_wdata;
  logic        src_error;
  logic [AW-1:0] src_idx;
  logic [3:0]  src_be;
  logic [31:0] src_wlanes;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] fmt_rdata;

  assign bus.req_ready  = (state_q != StBusy);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

  assign accept     = bus.req_valid & bus.req_ready;
  assign enter_resp = Direct ? accept : ((state_q == StBusy) && (cnt_q == 2'd1));

  assign src_write    = Direct ? bus.req_write    : cap_write;
  assign src_size     = Direct ? bus.req_size     : cap_size;
  assign src_unsigned = Direct ? bus.req_unsigned : cap_unsigned;
  assign src_addr     = Direct ? bus.req_addr     : cap_addr;
  assign src_wdata    = Direct ? bus.req_wdata    : cap_wdata;

  assign src_idx = src_addr[AW+1:2];

  // Error decode, byte enables and lane-replicated write data
  always_comb begin
    src_error  = 1'b0;
    src_be     = 4'b0000;
    src_wlanes = src_wdata;
    unique case (src_size)
      2'b00: begin
        src_be     = 4'b0001 << src_addr[1:0];
        src_wlanes = {4{src_wdata[7:0]}};
      end
      2'b01: begin
        src_error  = src_addr[0];
        src_be     = src_addr[1] ? 4'b1100 : 4'b0011;
        src_wlanes = {2{src_wdata[15:0]}};
      end
      2'b10: begin
        src_error  = (src_addr[1:0] != 2'b00);
        src_be     = 4'b1111;
      end
      default: src_error = 1'b1;
    endcase
    // Word index beyond the array: any address bit above the index field set
    if (|src_addr[31:AW+2]) begin
      src_error = 1'b1;
    end
  end

  // Array write and read capture share the edge that enters RESP. Writes are gated by
  // rst so a request presented during reset cannot modify the array.
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      rd_word <= mem[src_idx];
      if (rst && src_write && !src_error) begin
        for (int b = 0; b < 4; b++) begin
          if (src_be[b]) begin
            mem[src_idx][8*b +: 8] <= src_wlanes[8*b +: 8];
          end
        end
      end
    end
  end

  // Lane select and extension of the captured word, evaluated during RESP
  always_comb begin
    sel_byte  = rd_word[{rd_lane, 3'b000} +: 8];
    sel_half  = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
    fmt_rdata = rd_word;
    unique case (rd_size)
      2'b00:   fmt_rdata = {{24{~rd_unsigned & sel_byte[7]}}, sel_byte};
      2'b01:   fmt_rdata = {{16{~rd_unsigned & sel_half[15]}}, sel_half};
      default: fmt_rdata = rd_word;
    endcase
    if (rd_write || rd_error) begin
      fmt_rdata = 32'h0;
    end
  end

  // Control FSM, capture registers and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      cap_write    <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= 32'h0;
      cap_wdata    <= 32'h0;
      rd_write     <= 1'b0;
      rd_error     <= 1'b0;
      rd_unsigned  <= 1'b0;
      rd_size      <= 2'b00;
      rd_lane      <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      // RESP is the cycle in which the formatted result is registered to the outputs
      resp_valid_q <= (state_q == StResp);
      if (state_q == StResp) begin
        resp_rdata_q <= fmt_rdata;
        resp_error_q <= rd_error;
      end

      if (accept) begin
        cap_write    <= bus.req_write;
        cap_size     <= bus.req_size;
        cap_unsigned <= bus.req_unsigned;
        cap_addr     <= bus.req_addr;
        cap_wdata    <= bus.req_wdata;
      end

      if (enter_resp) begin
        rd_write    <= src_write;
        rd_error    <= src_error;
        rd_unsigned <= src_unsigned;
        rd_size     <= src_size;
        rd_lane     <= src_addr[1:0];
      end

      case (state_q)
        StIdle, StResp: begin
          if (accept) begin
            if (Direct) begin
              state_q <= StResp;
            end else begin
              state_q <= StBusy;
              cnt_q   <= CntLoad;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q <= StResp;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: three instances (LATENCY 1, 3 and 4) driven with
// directed and random traffic; a byte-array reference model predicts every response.
module tb_data_memory_unit;

  localparam int unsigned DEPTH = 1024;
  localparam int          NB    = 4 * DEPTH;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b000;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         lat_of [3] = '{1, 3, 4};
  int         last_acc [3] = '{-100, -100, -100};
  bit         ready_chk_en = 1'b0;
  exp_t       exp0 [$];
  exp_t       exp1 [$];
  exp_t       exp2 [$];
  logic [7:0] mdl [3][NB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_unit_if bus0 ();
  data_memory_unit_if bus1 ();
  data_memory_unit_if bus2 ();

  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(1)) u_dut0 (.clk(clk), .rst(rst_v[0]), .bus(bus0));
  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(3)) u_dut1 (.clk(clk), .rst(rst_v[1]), .bus(bus1));
  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(4)) u_dut2 (.clk(clk), .rst(rst_v[2]), .bus(bus2));

  task automatic drive(input int idx, input bit v, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] wd);
    case (idx)
      0: begin
        bus0.req_valid = v; bus0.req_write = wr; bus0.req_size = sz;
        bus0.req_unsigned = uns; bus0.req_addr = a; bus0.req_wdata = wd;
      end
      1: begin
        bus1.req_valid = v; bus1.req_write = wr; bus1.req_size = sz;
        bus1.req_unsigned = uns; bus1.req_addr = a; bus1.req_wdata = wd;
      end
      default: begin
        bus2.req_valid = v; bus2.req_write = wr; bus2.req_size = sz;
        bus2.req_unsigned = uns; bus2.req_addr = a; bus2.req_wdata = wd;
      end
    endcase
  endtask

  function automatic logic get_ready(input int idx);
    case (idx)
      0:       return bus0.req_ready;
      1:       return bus1.req_ready;
      default: return bus2.req_ready;
    endcase
  endfunction

  task automatic get_resp(input int idx, output logic rv, output logic [31:0] rd,
                          output logic er);
    case (idx)
      0:       begin rv = bus0.resp_valid; rd = bus0.resp_rdata; er = bus0.resp_error; end
      1:       begin rv = bus1.resp_valid; rd = bus1.resp_rdata; er = bus1.resp_error; end
      default: begin rv = bus2.resp_valid; rd = bus2.resp_rdata; er = bus2.resp_error; end
    endcase
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0:       return exp0.size();
      1:       return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Reference model: the memory is a flat byte array addressed by byte address.
  task automatic model_op(input int idx, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err);
    int          n;
    logic [31:0] v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'(NB));
    rd  = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int k = 0; k < n; k++) mdl[idx][int'(a) + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(mdl[idx][int'(a) + k]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endtask

  // Present a request at a falling edge and hold it until the DUT accepts it; returns
  // just after the accepting rising edge with the request still driven.
  task automatic issue(input int idx, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    logic        err;
    exp_t        e;
    bit          done;
    model_op(idx, wr, sz, uns, a, wd, rd, err);
    @(negedge clk);
    drive(idx, 1'b1, wr, sz, uns, a, wd);
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      if (get_ready(idx)) begin
        e.rdata = rd;
        e.err   = err;
        e.cyc   = cyc + 1 + lat_of[idx];
        case (idx)
          0:       exp0.push_back(e);
          1:       exp1.push_back(e);
          default: exp2.push_back(e);
        endcase
        last_acc[idx] = cyc + 1;
        done = 1'b1;
      end
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut%0d: got ready=0 want accept within 20 cycles", idx);
    end
  endtask

  task automatic idle(input int idx);
    @(negedge clk);
    drive(idx, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain(input int idx);
    int t;
    t = 0;
    while (qsize(idx) != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (qsize(idx) != 0) begin
      bad++;
      $display("FAIL drain dut%0d: got %0d pending responses want 0", idx, qsize(idx));
    end
  endtask

  task automatic rand_op(input int idx);
    int          r;
    logic [1:0]  sz;
    logic [31:0] a;
    r  = $urandom_range(0, 99);
    sz = (r < 5) ? 2'd3 : 2'($urandom_range(0, 2));
    a  = $urandom_range(0, 255);
    if (r >= 20 && r < 60) a = a & ~((32'd1 << sz) - 32'd1);
    if (r >= 90 && r < 95) a = 32'h8000_0000 | a;
    if (r >= 95) a = 32'h1000 + 32'($urandom_range(0, 255));
    issue(idx, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  task automatic prefill(input int idx);
    for (int w = 0; w < 64; w++) issue(idx, 1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom);
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation,
  // including the cycle at which it arrives.
  task automatic mon(input int idx);
    logic        rv;
    logic        er;
    logic [31:0] rd;
    exp_t        e;
    get_resp(idx, rv, rd, er);
    if (rv) begin
      total++;
      if (qsize(idx) == 0) begin
        bad++;
        $display("FAIL unexpected_resp dut%0d: got resp_valid=1 want no response (cyc %0d)",
                 idx, cyc);
      end else begin
        case (idx)
          0:       e = exp0.pop_front();
          1:       e = exp1.pop_front();
          default: e = exp2.pop_front();
        endcase
        if (rd !== e.rdata || er !== e.err || cyc != e.cyc) begin
          bad++;
          $display("FAIL resp dut%0d: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                   idx, rd, er, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) if (rst_v[0]) mon(0);
  always @(negedge clk) if (rst_v[1]) mon(1);
  always @(negedge clk) if (rst_v[2]) mon(2);

  // Latency-3 instance: req_ready low for the two cycles following each accept
  always @(negedge clk) begin
    if (ready_chk_en) begin
      total++;
      if (bus1.req_ready !== !(cyc >= last_acc[1] && cyc <= last_acc[1] + 1)) begin
        bad++;
        $display("FAIL ready_l3: got %b want %b (cyc %0d)", bus1.req_ready,
                 !(cyc >= last_acc[1] && cyc <= last_acc[1] + 1), cyc);
      end
    end
  end

  initial begin
    logic        rv;
    logic        er;
    logic [31:0] rd;
    logic [7:0]  saved [4];

    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      get_resp(i, rv, rd, er);
      chk($sformatf("reset_ready%0d", i), 32'(get_ready(i)), 32'd1);
      chk($sformatf("reset_valid%0d", i), 32'(rv), 32'd0);
      chk($sformatf("reset_rdata%0d", i), rd, 32'h0);
      chk($sformatf("reset_error%0d", i), 32'(er), 32'd0);
    end
    #2 rst_v = 3'b111;

    // Latency 1: store/load back to back, merges, errors, then random traffic
    prefill(0);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hdeadbeef);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
    issue(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    issue(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h23, 32'hFFFF);
    issue(0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    for (int n = 0; n < 300; n++) rand_op(0);
    idle(0);
    drain(0);

    // Latency 3: requests held back to back, ready pattern checked every cycle
    ready_chk_en = 1'b1;
    prefill(1);
    issue(1, 1'b1, 2'd0, 1'b0, 32'h31, 32'h5A);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    issue(1, 1'b0, 2'd0, 1'b0, 32'h31, 32'h0);
    for (int n = 0; n < 150; n++) rand_op(1);
    idle(1);
    drain(1);
    ready_chk_en = 1'b0;

    // Latency 4: reset two cycles into an in-flight store
    issue(2, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678);
    idle(2);
    drain(2);
    for (int k = 0; k < 4; k++) saved[k] = mdl[2][16'h40 + k];
    issue(2, 1'b1, 2'd2, 1'b0, 32'h40, 32'h55);
    idle(2);
    @(posedge clk);
    @(posedge clk);
    #2 rst_v[2] = 1'b0;
    exp2.delete();
    for (int k = 0; k < 4; k++) mdl[2][16'h40 + k] = saved[k];
    #1;
    get_resp(2, rv, rd, er);
    chk("rst_mid_valid", 32'(rv), 32'd0);
    chk("rst_mid_ready", 32'(get_ready(2)), 32'd1);
    chk("rst_mid_rdata", rd, 32'h0);
    chk("rst_mid_error", 32'(er), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_v[2] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      get_resp(2, rv, rd, er);
      chk("rst_no_resp", 32'(rv), 32'd0);
    end
    issue(2, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    idle(2);
    drain(2);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
